// File: rtl/prbs8_checker.sv
// Receive-side checker for the 8-bit PRBS (x^8+x^6+x^5+x^4+1, shift-left) link stream.
// Self-synchronises in HUNT, flywheels the reference in LOCKED, and keeps saturating error statistics.
module prbs8_checker #(
  parameter int LOCK_COUNT = 4,
  parameter int LOSS_COUNT = 3,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] byte_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] bit_err_cnt
);

  typedef enum logic [0:0] {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [4:0]       LOCK_RUN = 5'(LOCK_COUNT);
  localparam logic [4:0]       LOSS_RUN = 5'(LOSS_COUNT);

  function automatic logic [7:0] prbs_step(input logic [7:0] cur);
    return {cur[6:0], cur[7] ^ cur[5] ^ cur[4] ^ cur[3]};
  endfunction

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] sum;
    sum = 4'd0;
    for (int i = 0; i < 8; i++) begin
      sum = sum + {3'b000, v[i]};
    end
    return sum;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + CNT_ONE;
  endfunction

  // Widened sum so an overflowing addition clamps instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] c,
                                               input logic [3:0]       add);
    logic [CNT_W:0] sum;
    sum = {1'b0, c} + (CNT_W+1)'(add);
    return sum[CNT_W] ? CNT_MAX : sum[CNT_W-1:0];
  endfunction

  state_t           state_r;
  logic [7:0]       ref_r;
  logic             seed_ok_r;
  logic [3:0]       match_run_r;
  logic [3:0]       miss_run_r;
  logic             locked_r;
  logic             err_pulse_r;
  logic [CNT_W-1:0] byte_cnt_r;
  logic [CNT_W-1:0] err_cnt_r;
  logic [CNT_W-1:0] bit_err_cnt_r;

  logic [7:0]       exp_s;
  logic [7:0]       diff_s;
  logic             mismatch_s;
  logic [3:0]       bit_errs_s;
  logic [4:0]       match_next_s;
  logic [4:0]       miss_next_s;
  logic             cnt_en_s;

  // Expected byte, error pattern and run-length increments for the current sample.
  always_comb begin
    exp_s        = prbs_step(ref_r);
    diff_s       = in_data ^ exp_s;
    mismatch_s   = (diff_s != 8'h00);
    bit_errs_s   = popcount8(diff_s);
    match_next_s = {1'b0, match_run_r} + 5'd1;
    miss_next_s  = {1'b0, miss_run_r} + 5'd1;
    cnt_en_s     = in_valid && (state_r == LOCKED);
  end

  // Lock FSM: reference tracking, run counters and registered locked/err_pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= HUNT;
      ref_r       <= 8'h00;
      seed_ok_r   <= 1'b0;
      match_run_r <= 4'd0;
      miss_run_r  <= 4'd0;
      locked_r    <= 1'b0;
      err_pulse_r <= 1'b0;
    end else begin
      err_pulse_r <= 1'b0;
      if (in_valid) begin
        case (state_r)
          HUNT: begin
            // All-zero is the LFSR lock-up state and can never be a valid seed.
            if (in_data == 8'h00) begin
              seed_ok_r   <= 1'b0;
              match_run_r <= 4'd0;
            end else begin
              ref_r     <= in_data;
              seed_ok_r <= 1'b1;
              if (seed_ok_r && !mismatch_s) begin
                match_run_r <= match_next_s[3:0];
                if (match_next_s == LOCK_RUN) begin
                  state_r    <= LOCKED;
                  locked_r   <= 1'b1;
                  miss_run_r <= 4'd0;
                end
              end else begin
                match_run_r <= 4'd0;
              end
            end
          end
          LOCKED: begin
            // Flywheel: a corrupted byte must not poison the reference.
            ref_r <= exp_s;
            if (mismatch_s) begin
              err_pulse_r <= 1'b1;
              miss_run_r  <= miss_next_s[3:0];
              if (miss_next_s == LOSS_RUN) begin
                state_r     <= HUNT;
                locked_r    <= 1'b0;
                match_run_r <= 4'd0;
                seed_ok_r   <= 1'b0;
                miss_run_r  <= 4'd0;
              end
            end else begin
              miss_run_r <= 4'd0;
            end
          end
          default: begin
            state_r     <= HUNT;
            locked_r    <= 1'b0;
            seed_ok_r   <= 1'b0;
            match_run_r <= 4'd0;
            miss_run_r  <= 4'd0;
          end
        endcase
      end
    end
  end

  // Saturating statistics; clear wins over a concurrent sample.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      byte_cnt_r    <= CNT_ZERO;
      err_cnt_r     <= CNT_ZERO;
      bit_err_cnt_r <= CNT_ZERO;
    end else if (clear) begin
      byte_cnt_r    <= CNT_ZERO;
      err_cnt_r     <= CNT_ZERO;
      bit_err_cnt_r <= CNT_ZERO;
    end else if (cnt_en_s) begin
      byte_cnt_r <= sat_inc(byte_cnt_r);
      if (mismatch_s) begin
        err_cnt_r     <= sat_inc(err_cnt_r);
        bit_err_cnt_r <= sat_add(bit_err_cnt_r, bit_errs_s);
      end
    end
  end

  assign locked      = locked_r;
  assign err_pulse   = err_pulse_r;
  assign byte_cnt    = byte_cnt_r;
  assign err_cnt     = err_cnt_r;
  assign bit_err_cnt = bit_err_cnt_r;

endmodule

// File: tb/tb_prbs8_checker.sv
// Directed bench for prbs8_checker: lock, errors, loss/relock, stuck-zero, bubbles, clear,
// saturation (second instance with 4-bit counters) and mid-stream reset.
module tb_prbs8_checker;

  logic        clk;
  logic        rst_n;
  logic        clear;
  logic        in_valid;
  logic [7:0]  in_data;

  logic        locked;
  logic        err_pulse;
  logic [15:0] byte_cnt;
  logic [15:0] err_cnt;
  logic [15:0] bit_err_cnt;

  logic        locked4;
  logic        err_pulse4;
  logic [3:0]  byte_cnt4;
  logic [3:0]  err_cnt4;
  logic [3:0]  bit_err_cnt4;

  int n_assert = 0;
  int n_fail   = 0;

  prbs8_checker dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (clear),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .locked      (locked),
    .err_pulse   (err_pulse),
    .byte_cnt    (byte_cnt),
    .err_cnt     (err_cnt),
    .bit_err_cnt (bit_err_cnt)
  );

  prbs8_checker #(.CNT_W(4)) dut4 (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (clear),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .locked      (locked4),
    .err_pulse   (err_pulse4),
    .byte_cnt    (byte_cnt4),
    .err_cnt     (err_cnt4),
    .bit_err_cnt (bit_err_cnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] prbs_next(input logic [7:0] cur);
    return {cur[6:0], cur[7] ^ cur[5] ^ cur[4] ^ cur[3]};
  endfunction

  // Apply one cycle of inputs and return 1 time unit after the sampling edge.
  task automatic tick(input logic v, input logic [7:0] d, input logic c);
    in_valid = v;
    in_data  = d;
    clear    = c;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  logic [7:0] lf;

  initial begin
    rst_n    = 1'b0;
    clear    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    // Reset asserted with valid and clear active to show it overrides both.
    tick(1'b1, 8'h01, 1'b1);
    tick(1'b1, 8'h02, 1'b0);
    chk("rst_locked", {31'd0, locked}, 32'd0);
    chk("rst_err_pulse", {31'd0, err_pulse}, 32'd0);
    chk("rst_byte_cnt", {16'd0, byte_cnt}, 32'd0);
    chk("rst_err_cnt", {16'd0, err_cnt}, 32'd0);
    chk("rst_bit_err_cnt", {16'd0, bit_err_cnt}, 32'd0);
    rst_n = 1'b1;

    // Lock acquisition: seed plus four matches.
    tick(1'b1, 8'h01, 1'b0);
    chk("lock_seed", {31'd0, locked}, 32'd0);
    tick(1'b1, 8'h02, 1'b0);
    tick(1'b1, 8'h04, 1'b0);
    tick(1'b1, 8'h08, 1'b0);
    chk("lock_early", {31'd0, locked}, 32'd0);
    tick(1'b1, 8'h11, 1'b0);
    chk("lock_rise", {31'd0, locked}, 32'd1);
    chk("lock_byte_cnt", {16'd0, byte_cnt}, 32'd0);

    // Single-bit error in place of 0x23.
    tick(1'b1, 8'h22, 1'b0);
    chk("err1_pulse", {31'd0, err_pulse}, 32'd1);
    chk("err1_err_cnt", {16'd0, err_cnt}, 32'd1);
    chk("err1_bit_cnt", {16'd0, bit_err_cnt}, 32'd1);
    chk("err1_byte_cnt", {16'd0, byte_cnt}, 32'd1);
    tick(1'b1, 8'h47, 1'b0);
    chk("err1_next_pulse", {31'd0, err_pulse}, 32'd0);
    chk("err1_next_err_cnt", {16'd0, err_cnt}, 32'd1);
    chk("err1_locked", {31'd0, locked}, 32'd1);
    tick(1'b1, 8'h8E, 1'b0);
    chk("clean_byte_cnt", {16'd0, byte_cnt}, 32'd3);

    // Loss of lock: expected 1C, 38, 71 -> popcounts 5, 5, 4.
    tick(1'b1, 8'hFF, 1'b0);
    chk("loss1_pulse", {31'd0, err_pulse}, 32'd1);
    chk("loss1_locked", {31'd0, locked}, 32'd1);
    tick(1'b1, 8'hFF, 1'b0);
    chk("loss2_locked", {31'd0, locked}, 32'd1);
    tick(1'b1, 8'hFF, 1'b0);
    chk("loss3_locked", {31'd0, locked}, 32'd0);
    chk("loss_err_cnt", {16'd0, err_cnt}, 32'd4);
    chk("loss_bit_cnt", {16'd0, bit_err_cnt}, 32'd15);
    chk("loss_byte_cnt", {16'd0, byte_cnt}, 32'd6);

    // Relock at a different phase.
    tick(1'b1, 8'h47, 1'b0);
    tick(1'b1, 8'h8E, 1'b0);
    tick(1'b1, 8'h1C, 1'b0);
    tick(1'b1, 8'h38, 1'b0);
    chk("relock_early", {31'd0, locked}, 32'd0);
    tick(1'b1, 8'h71, 1'b0);
    chk("relock_rise", {31'd0, locked}, 32'd1);
    chk("relock_byte_hold", {16'd0, byte_cnt}, 32'd6);
    tick(1'b1, 8'hE2, 1'b0);
    chk("relock_byte_cnt", {16'd0, byte_cnt}, 32'd7);
    chk("relock_err_cnt", {16'd0, err_cnt}, 32'd4);

    // Stuck-zero input from reset.
    rst_n = 1'b0;
    tick(1'b1, 8'h00, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) tick(1'b1, 8'h00, 1'b0);
    chk("zero_locked", {31'd0, locked}, 32'd0);
    chk("zero_byte_cnt", {16'd0, byte_cnt}, 32'd0);
    chk("zero_err_cnt", {16'd0, err_cnt}, 32'd0);
    tick(1'b1, 8'h01, 1'b0);
    tick(1'b1, 8'h02, 1'b0);
    tick(1'b1, 8'h04, 1'b0);
    tick(1'b1, 8'h08, 1'b0);
    chk("zero_lock_early", {31'd0, locked}, 32'd0);
    tick(1'b1, 8'h11, 1'b0);
    chk("zero_lock_rise", {31'd0, locked}, 32'd1);

    // Bubbles: invalid cycles carry junk that must be ignored.
    tick(1'b1, 8'h23, 1'b0);
    chk("bub_byte1", {16'd0, byte_cnt}, 32'd1);
    tick(1'b0, 8'h55, 1'b0);
    chk("bub_hold", {16'd0, byte_cnt}, 32'd1);
    chk("bub_no_pulse", {31'd0, err_pulse}, 32'd0);
    tick(1'b1, 8'h47, 1'b0);
    tick(1'b0, 8'hAA, 1'b0);
    tick(1'b1, 8'h8E, 1'b0);
    chk("bub_byte3", {16'd0, byte_cnt}, 32'd3);
    chk("bub_err_cnt", {16'd0, err_cnt}, 32'd0);
    chk("bub_bit_cnt", {16'd0, bit_err_cnt}, 32'd0);

    // Clear together with a mismatching byte (expected 1C).
    tick(1'b1, 8'h00, 1'b1);
    chk("clr_byte_cnt", {16'd0, byte_cnt}, 32'd0);
    chk("clr_err_cnt", {16'd0, err_cnt}, 32'd0);
    chk("clr_bit_cnt", {16'd0, bit_err_cnt}, 32'd0);
    chk("clr_locked", {31'd0, locked}, 32'd1);
    tick(1'b1, 8'h38, 1'b0);
    chk("clr_after_byte", {16'd0, byte_cnt}, 32'd1);
    chk("clr_after_err", {16'd0, err_cnt}, 32'd0);
    chk("clr_after_locked", {31'd0, locked}, 32'd1);

    // Saturation: fresh lock, then 17 good/bad pairs with all 8 bits inverted.
    rst_n = 1'b0;
    tick(1'b1, 8'h01, 1'b0);
    rst_n = 1'b1;
    lf = 8'h01;
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, lf, 1'b0);
      lf = prbs_next(lf);
    end
    chk("sat_lock", {31'd0, locked4}, 32'd1);
    for (int i = 0; i < 17; i++) begin
      tick(1'b1, lf, 1'b0);
      lf = prbs_next(lf);
      tick(1'b1, lf ^ 8'hFF, 1'b0);
      lf = prbs_next(lf);
      if (i == 0) chk("sat_bit_first", {28'd0, bit_err_cnt4}, 32'd8);
      if (i == 1) chk("sat_bit_clamp", {28'd0, bit_err_cnt4}, 32'd15);
      if (i == 13) chk("sat_err_14", {28'd0, err_cnt4}, 32'd14);
      if (i == 14) chk("sat_err_15", {28'd0, err_cnt4}, 32'd15);
    end
    chk("sat_err_hold", {28'd0, err_cnt4}, 32'd15);
    chk("sat_byte_hold", {28'd0, byte_cnt4}, 32'd15);
    chk("sat_bit_hold", {28'd0, bit_err_cnt4}, 32'd15);
    chk("wide_err_cnt", {16'd0, err_cnt}, 32'd17);
    chk("wide_bit_cnt", {16'd0, bit_err_cnt}, 32'd136);
    chk("wide_byte_cnt", {16'd0, byte_cnt}, 32'd34);
    chk("sat_locked", {31'd0, locked4}, 32'd1);
    chk("sat_pulse", {31'd0, err_pulse}, 32'd1);

    // Reset mid-stream with a valid sample present.
    rst_n = 1'b0;
    tick(1'b1, lf, 1'b0);
    chk("mid_rst_locked", {31'd0, locked}, 32'd0);
    chk("mid_rst_pulse", {31'd0, err_pulse}, 32'd0);
    chk("mid_rst_byte", {16'd0, byte_cnt}, 32'd0);
    chk("mid_rst_err", {16'd0, err_cnt}, 32'd0);
    chk("mid_rst_bit", {16'd0, bit_err_cnt}, 32'd0);
    chk("mid_rst_err4", {28'd0, err_cnt4}, 32'd0);
    chk("mid_rst_locked4", {31'd0, locked4}, 32'd0);
    rst_n = 1'b1;
    tick(1'b0, 8'h00, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/prbs8_checker.md
Name: prbs8_checker

Overview:
Receive-side checker for the 8-bit PRBS stream that our LFSR generator drives out on uio_out. The generator shifts one bit per clock: next = {cur[6:0], cur[7]^cur[5]^cur[4]^cur[3]}, with the seed at 0x01. This block self-synchronises to that stream, acquires lock, and counts byte errors and bit errors for loopback and board-level link tests. It sits on the input side of a tile; its data input connects to uio_in or ui_in.

Parameters:
LOCK_COUNT, 4, consecutive matching bytes in HUNT required to declare lock (1..15)
LOSS_COUNT, 3, consecutive mismatching bytes in LOCKED that drop lock (1..15)
CNT_W, 16, width of all statistics counters

Ports:
clk  input  1  clock
rst_n  input  1  synchronous active-low reset
clear  input  1  synchronous clear of the statistics counters; lock state is unaffected
in_valid  input  1  in_data is a valid sample this cycle
in_data  input  8  received PRBS byte
locked  output  1  high while in state LOCKED
err_pulse  output  1  one-cycle pulse for each mismatching byte checked while LOCKED
byte_cnt  output  CNT_W  valid bytes checked while LOCKED (saturating)
err_cnt  output  CNT_W  mismatching bytes while LOCKED (saturating)
bit_err_cnt  output  CNT_W  total differing bits, popcount(in_data ^ expected), while LOCKED (saturating)

Behaviour:
- Interface:
  - Reset rst_n is synchronous, active-low.
  - Clock is clk.
  - All state is updated on the rising edge of clk.
- Reset values:
  - state = HUNT; ref = 0x00; seed_ok = 0.
  - match_run = 0; miss_run = 0.
  - locked = 0; err_pulse = 0.
  - All counters = 0.
- Expected value: exp = {ref[6:0], ref[7]^ref[5]^ref[4]^ref[3]}.
- Input handling:
  - Nothing changes on cycles where in_valid = 0, except that err_pulse returns to 0.
  - Bubbles in in_valid do not advance exp.
- Latency: all outputs are registered. The effect of a sample taken at edge N is visible after edge N.
- State HUNT, on in_valid:
  - If in_data == 0x00 (illegal LFSR state): seed_ok <= 0, match_run <= 0.
  - Else if seed_ok && in_data == exp: match_run++. If match_run+1 == LOCK_COUNT, go to LOCKED with miss_run <= 0.
  - Else: match_run <= 0.
  - In every nonzero case: ref <= in_data and seed_ok <= 1.
  - Counters and err_pulse do not change in HUNT.
- State LOCKED, on in_valid:
  - ref <= exp always (flywheel). A corrupted byte therefore produces exactly one mismatch and does not propagate.
  - byte_cnt++.
  - On match: miss_run <= 0.
  - On mismatch:
    - err_pulse <= 1; err_cnt++; bit_err_cnt += popcount (0..8); miss_run++.
    - If miss_run+1 == LOSS_COUNT: go to HUNT with match_run <= 0, seed_ok <= 0.
- Counter rules:
  - Saturation: each counter sticks at 2^CNT_W-1. bit_err_cnt clamps if the addition would overflow.
  - clear has priority over the increments in the same cycle: counters become 0 and the concurrent sample is not counted.
  - State, ref and the run counters still update normally during clear.
- Reset mid-operation: rst_n = 0 overrides everything, including in_valid and clear, and restores all reset values in one cycle.
- Reference sequence from seed 0x01: 01, 02, 04, 08, 11, 23, 47, 8E, ...

Test Plan:
1. Lock acquisition: reset, then drive 01, 02, 04, 08, 11 with in_valid = 1 every cycle -> locked rises after the 5th sample edge (1 seed + 4 matches). Counters stay 0 until locked, then byte_cnt increments 1 per byte.
2. Single error: while locked on a clean stream, replace 0x23 with 0x22 -> one err_pulse; err_cnt = 1; bit_err_cnt = 1; the next byte 0x47 matches; locked stays 1.
3. Loss of lock: while locked, inject 3 consecutive bad bytes (0xFF each time) -> err_cnt += 3 and locked falls after the 3rd. Then resume a valid stream at any phase -> relock after 5 valid bytes.
4. Stuck-zero input: drive 0x00 continuously from reset -> locked stays 0 and all counters stay 0. Switch to a valid stream -> lock after 5 bytes.
5. Bubbles and clear: a locked stream with in_valid toggling 1,0,1,0 -> no errors and byte_cnt counts only valid bytes. Assert clear together with a mismatching byte -> all counters read 0 next cycle and locked stays 1.
6. Saturation and reset: with CNT_W = 4, keep 16+ mismatches in flight within LOSS_COUNT windows (alternating good and bad bytes) -> err_cnt holds at 15. Assert rst_n = 0 mid-stream -> locked = 0 and counters = 0 on the next edge.
